// File: rtl/slc3_pkg.sv
// Shared SLC-3 types and widths for the memory bus port and its helpers.
package slc3_pkg;

  localparam int unsigned SLC3_DATA_W = 16;
  localparam int unsigned SLC3_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/slc3_wait_counter.sv
// Wait-state counter for SRAM accesses: counts 0..WAIT_CYCLES-1 and holds
// at the terminal value so it can never run past the last access cycle.
module slc3_wait_counter #(
  parameter  int unsigned WAIT_CYCLES = 2,
  localparam int unsigned CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  assign tc_c = (count == LAST);

  // Clear beats load beats increment; increment saturates at the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !tc_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/slc3_mem_bus_port.sv
// Memory-side DataBus endpoint: MAR/MDR registers plus the SRAM read/write
// cycle sequencer with a fixed number of wait states per access.
module slc3_mem_bus_port
  import slc3_pkg::*;
#(
  parameter int unsigned DATA_W      = SLC3_DATA_W,
  parameter int unsigned ADDR_W      = SLC3_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] DataBus,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              Ready,
  output logic              Busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  mem_state_t       state_q, state_d;
  logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt;

  slc3_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val('0),
    .en      (cnt_en),
    .count   (cnt),
    .tc_c    (cnt_tc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; a simultaneous read and write request resolves to the read.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemRead) begin
          state_d  = READ;
          cnt_load = 1'b1;
        end else if (MemWrite) begin
          state_d  = WRITE;
          cnt_load = 1'b1;
        end
      end
      READ, WRITE: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status and strobes are flops decoded from the upcoming state, so they
  // line up with the state register and never glitch on input changes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      mem_ce_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
    end else begin
      Ready    <= (state_d == DONE);
      Busy     <= (state_d != IDLE);
      mem_ce_n <= !((state_d == READ) || (state_d == WRITE));
      mem_oe_n <= (state_d != READ);
      mem_we_n <= (state_d != WRITE);
    end
  end

  // Bus loads are only honoured in IDLE, keeping MAR/MDR stable per access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      MAR <= '0;
      MDR <= '0;
    end else begin
      if (state_q == IDLE && LD_MAR) MAR <= ADDR_W'(DataBus);
      if (state_q == READ && cnt_tc) begin
        MDR <= mem_rdata;
      end else if (state_q == IDLE && LD_MDR) begin
        MDR <= DataBus;
      end
    end
  end

  assign mem_addr  = MAR;
  assign mem_wdata = MDR;

endmodule

// File: tb/tb_slc3_mem_bus_port.sv
// Directed bench for slc3_mem_bus_port: one instance with two wait states,
// one with a single wait state; SRAM returns address ^ 16'h8EEF.
module tb_slc3_mem_bus_port;

  logic        Clk = 1'b0;
  logic        Reset_n;
  always #5 Clk = ~Clk;

  // Instance A: WAIT_CYCLES = 2
  logic [15:0] a_bus;
  logic        a_ld_mar, a_ld_mdr, a_rd, a_wr;
  logic [15:0] a_mar, a_mdr, a_addr, a_wdata, a_rdata;
  logic        a_ready, a_busy, a_ce_n, a_oe_n, a_we_n;

  // Instance B: WAIT_CYCLES = 1
  logic [15:0] b_bus;
  logic        b_ld_mar, b_ld_mdr, b_rd, b_wr;
  logic [15:0] b_mar, b_mdr, b_addr, b_wdata, b_rdata;
  logic        b_ready, b_busy, b_ce_n, b_oe_n, b_we_n;

  assign a_rdata = a_addr ^ 16'h8EEF;
  assign b_rdata = b_addr ^ 16'h8EEF;

  slc3_mem_bus_port #(.WAIT_CYCLES(2)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .DataBus(a_bus),
    .LD_MAR(a_ld_mar), .LD_MDR(a_ld_mdr), .MemRead(a_rd), .MemWrite(a_wr),
    .MAR(a_mar), .MDR(a_mdr), .Ready(a_ready), .Busy(a_busy),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
    .mem_ce_n(a_ce_n), .mem_oe_n(a_oe_n), .mem_we_n(a_we_n)
  );

  slc3_mem_bus_port #(.WAIT_CYCLES(1)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .DataBus(b_bus),
    .LD_MAR(b_ld_mar), .LD_MDR(b_ld_mdr), .MemRead(b_rd), .MemWrite(b_wr),
    .MAR(b_mar), .MDR(b_mdr), .Ready(b_ready), .Busy(b_busy),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .mem_ce_n(b_ce_n), .mem_oe_n(b_oe_n), .mem_we_n(b_we_n)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] a_strb();
    return {29'd0, a_ce_n, a_oe_n, a_we_n};
  endfunction

  initial begin
    Reset_n = 1'b0;
    a_bus = '0; a_ld_mar = 0; a_ld_mdr = 0; a_rd = 0; a_wr = 0;
    b_bus = '0; b_ld_mar = 0; b_ld_mdr = 0; b_rd = 0; b_wr = 0;
    step(); step();
    check("rst_mar", 32'(a_mar), 32'h0);
    check("rst_mdr", 32'(a_mdr), 32'h0);
    check("rst_ready_busy", {30'd0, a_ready, a_busy}, 32'h0);
    check("rst_strobes", a_strb(), 32'h7);
    Reset_n = 1'b1;
    step();

    // Write 0xBEEF to 0x3000
    a_bus = 16'h3000; a_ld_mar = 1; step();
    a_ld_mar = 0; a_bus = 16'hBEEF; a_ld_mdr = 1; step();
    check("ld_mar", 32'(a_mar), 32'h3000);
    a_ld_mdr = 0; a_wr = 1; step();       // edge k
    a_wr = 0;
    check("ld_mdr", 32'(a_mdr), 32'hBEEF);
    check("wr_c1_strb", a_strb(), 32'h2);   // ce=0 oe=1 we=0
    check("wr_addr", 32'(a_addr), 32'h3000);
    check("wr_wdata", 32'(a_wdata), 32'hBEEF);
    check("wr_c1_ready", 32'(a_ready), 32'h0);
    step();
    check("wr_c2_strb", a_strb(), 32'h2);
    check("wr_c2_ready", 32'(a_ready), 32'h0);
    step();                               // cycle k+3
    check("wr_c3_strb", a_strb(), 32'h7);
    check("wr_c3_ready_busy", {30'd0, a_ready, a_busy}, 32'h3);
    step();
    check("wr_idle_ready_busy", {30'd0, a_ready, a_busy}, 32'h0);

    // Read 0x3000 with write/load attempts during READ
    a_rd = 1; step();                     // edge k
    a_rd = 0;
    check("rd_c1_strb", a_strb(), 32'h1);   // ce=0 oe=0 we=1
    check("rd_c1_busy", 32'(a_busy), 32'h1);
    a_bus = 16'h1234; a_ld_mar = 1; a_wr = 1; step();
    a_ld_mar = 0; a_wr = 0;
    check("rd_c2_strb", a_strb(), 32'h1);
    check("rd_mar_held", 32'(a_mar), 32'h3000);
    step();
    check("rd_ready", 32'(a_ready), 32'h1);
    check("rd_mdr", 32'(a_mdr), 32'hBEEF);
    check("rd_done_strb", a_strb(), 32'h7);
    a_bus = 16'h5555; a_ld_mar = 1; step();  // load during DONE ignored
    a_ld_mar = 0;
    check("rd_busy_fall", {30'd0, a_ready, a_busy}, 32'h0);
    check("done_load_ignored", 32'(a_mar), 32'h3000);
    step();
    check("no_write_after", a_strb(), 32'h7);

    // First IDLE cycle load takes effect (idle here), then restore MAR
    a_bus = 16'h4444; a_ld_mar = 1; step();
    check("idle_load", 32'(a_mar), 32'h4444);
    a_bus = 16'h3000; step();
    a_ld_mar = 0;

    // Read and write together: read only
    a_rd = 1; a_wr = 1; step();
    a_rd = 0; a_wr = 0;
    check("both_c1_strb", a_strb(), 32'h1);
    step();
    check("both_c2_strb", a_strb(), 32'h1);
    step();
    check("both_ready", 32'(a_ready), 32'h1);
    check("both_we_n", 32'(a_we_n), 32'h1);
    step();
    check("both_idle_strb", a_strb(), 32'h7);

    // Reset in the middle of a read
    a_rd = 1; step();
    a_rd = 0;
    check("mid_rd_strb", a_strb(), 32'h1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_strb", a_strb(), 32'h7);
    check("async_mar_mdr", {a_mar, a_mdr}, 32'h0);
    check("async_ready_busy", {30'd0, a_ready, a_busy}, 32'h0);
    step();
    check("rst_hold_ready", 32'(a_ready), 32'h0);
    step();
    Reset_n = 1'b1;
    step();
    check("post_rst_ready", 32'(a_ready), 32'h0);
    a_rd = 1; step();
    a_rd = 0;
    check("post_rst_strb", a_strb(), 32'h1);
    step(); step();
    check("post_rst_ready2", 32'(a_ready), 32'h1);
    check("post_rst_mdr", 32'(a_mdr), 32'h8EEF);
    step();

    // Single wait state, back-to-back reads of 0x0000 and 0x0001
    b_rd = 1; step();                     // edge k
    b_rd = 0;
    check("b_c1_oe", 32'(b_oe_n), 32'h0);
    check("b_c1_ready", 32'(b_ready), 32'h0);
    step();                               // cycle k+2
    check("b_ready1", 32'(b_ready), 32'h1);
    check("b_mdr1", 32'(b_mdr), 32'h8EEF);
    step();                               // cycle k+3, IDLE
    check("b_idle_busy", 32'(b_busy), 32'h0);
    b_bus = 16'h0001; b_ld_mar = 1; b_rd = 1; step();
    b_ld_mar = 0; b_rd = 0;
    check("b_mar2", 32'(b_mar), 32'h0001);
    check("b_c4_strb", {29'd0, b_ce_n, b_oe_n, b_we_n}, 32'h1);
    step();                               // cycle k+5
    check("b_ready2", 32'(b_ready), 32'h1);
    check("b_mdr2", 32'(b_mdr), 32'h8EEE);
    step();
    check("b_end_ready", 32'(b_ready), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
